arb_requester: RTL

- Requester-side agent for the round-robin arbiter grant protocol.
- Buffers posted write commands (addr+data) in a local FIFO, raises arb_req, and waits for arb_grant.
- Once granted, drains up to MAX_BURST beats onto the shared bus, then drops arb_req so the arbiter can rotate.
- One instance sits in front of each bus master port that feeds an arbiter req/grant bit.

---
 rtl/arb_req_pkg.sv | 16 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/arb_requester.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the arbiter requester agent.
package arb_req_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RELEASE
    } state_t;

    // Occupancy counter needs one extra bit so a full FIFO is representable.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic registered FIFO with full/empty/level flags; async active-low reset.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW + 1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    // No bypass: a full FIFO refuses a push even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// Requester-side agent: queues posted writes, requests the arbiter and drains bursts.
// Optional grant-wait watchdog (timeout_err) enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_BURST      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                push_valid,
    output logic                                push_ready,
    input  logic [ADDR_WIDTH-1:0]               push_addr,
    input  logic [DATA_WIDTH-1:0]               push_data,
    output logic                                arb_req,
    input  logic                                arb_grant,
    output logic                                bus_valid,
    input  logic                                bus_ready,
    output logic [ADDR_WIDTH-1:0]               bus_addr,
    output logic [DATA_WIDTH-1:0]               bus_data,
    output logic [level_width(FIFO_DEPTH)-1:0]  fifo_level,
`ifdef ARB_REQ_TIMEOUT_EN
    output logic                                timeout_err,
`endif
    output logic                                active
);

    localparam int unsigned LEVEL_W = level_width(FIFO_DEPTH);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_BURST < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("arb_requester: invalid parameter set");
    end

    state_t             state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
    logic               arb_req_q, arb_req_d;
    cmd_t               push_cmd, head_cmd;
    logic               fifo_full, fifo_empty;
    logic               push_fire, pop_fire, last_pop;

    assign push_cmd   = '{addr: push_addr, data: push_data};
    assign push_ready = !fifo_full;
    assign push_fire  = push_valid && push_ready;
    assign bus_valid  = (state_q == XFER) && arb_grant && !fifo_empty;
    assign pop_fire   = bus_valid && bus_ready;
    assign bus_addr   = head_cmd.addr;
    assign bus_data   = head_cmd.data;
    assign arb_req    = arb_req_q;
    assign active     = (state_q != IDLE);
    assign burst_inc  = burst_q + BURST_W'(1);
    // This pop takes the last queued entry unless a push refills it in the same cycle.
    assign last_pop   = pop_fire && (fifo_level == LEVEL_W'(1)) && !push_fire;

    sync_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_valid),
        .pop   (pop_fire),
        .wdata (push_cmd),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = REQ;
            end
            REQ: begin
                if (arb_grant) begin
                    state_d = XFER;
                    burst_d = '0;
                end
            end
            XFER: begin
                if (pop_fire) begin
                    burst_d = burst_inc;
                    if (burst_inc == BURST_LAST || last_pop) state_d = RELEASE;
                end else if (!arb_grant) begin
                    state_d = REQ;
                end
            end
            RELEASE: begin
                // Wait for the registered grant to clear so it is never reused.
                if (!arb_grant) state_d = fifo_empty ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
        arb_req_d = (state_d == REQ) || (state_d == XFER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            arb_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            arb_req_q <= arb_req_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_err_q, timeout_err_d;

    always_comb begin
        wait_d        = '0;
        timeout_err_d = timeout_err_q;
        if (state_q == REQ) begin
            wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WAIT_W'(1);
            if (wait_q == WAIT_LAST) timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule
